// File: rtl/encode_mux_arb_pkg.sv
// Shared definitions for the burst-granular round-robin arbiter:
// state encoding and an elaboration-time width helper.
package encode_mux_arb_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  function automatic int unsigned ceil_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/encode_mux_arb_if.sv
// Requester-side and downstream-side signals of encode_mux_arb.
// master = requesters + downstream sink, slave = the arbiter.
interface encode_mux_arb_if #(
  parameter int WIDTH     = 32,
  parameter int CNT       = 5,
  parameter int CNT_WIDTH = 3
);
  logic [CNT-1:0]       req_valid;
  logic [CNT-1:0]       req_last;
  logic [WIDTH*CNT-1:0] req_data;
  logic [CNT-1:0]       req_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic [CNT_WIDTH-1:0] out_src;
  logic                 out_ready;
  logic                 busy;

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src, busy
  );
endinterface

// File: rtl/encode_mux_arb_rr_pick.sv
// Rotating-priority picker: first set bit of req scanning ptr, ptr+1, ...
// wrapping at CNT. Purely combinational.
module rr_pick #(
  parameter int CNT       = 5,
  parameter int CNT_WIDTH = 3
) (
  input  logic [CNT-1:0]       req,
  input  logic [CNT_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [CNT_WIDTH-1:0] idx
);
  localparam int NSEL = 1 << CNT_WIDTH;

  // Padded so a CNT_WIDTH-bit index always lands inside the vector.
  logic [NSEL-1:0]      req_pad;
  logic [CNT_WIDTH-1:0] sel;
  int                   jj;

  assign req_pad = NSEL'(req);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    jj    = 0;
    sel   = '0;
    for (int k = 0; k < CNT; k++) begin
      jj = int'(ptr) + k;
      if (jj >= CNT) jj = jj - CNT;
      sel = CNT_WIDTH'(jj);
      if (!found && req_pad[sel]) begin
        found = 1'b1;
        idx   = sel;
      end
    end
  end
endmodule

// File: rtl/encode_mux_arb.sv
// Burst-granular round-robin arbiter sharing one registered valid/ready
// output stage among CNT requesters; grant is held until the last beat.
module encode_mux_arb
  import encode_mux_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT       = 5,
  parameter int CNT_WIDTH = 3
) (
  input logic               clk,
  input logic               rst_n,
  encode_mux_arb_if.slave   bus
);
  localparam int NSEL = 1 << CNT_WIDTH;

  if (CNT < 2 || ceil_log2(CNT) > CNT_WIDTH) begin : g_bad_cfg
    $error("encode_mux_arb: CNT_WIDTH too small for CNT");
  end

  logic                        state, state_nxt;
  logic [CNT_WIDTH-1:0]        ptr, gnt;
  logic                        pick_found;
  logic [CNT_WIDTH-1:0]        pick_idx;
  logic                        out_free, beat, beat_last;
  logic [NSEL-1:0]             valid_pad, last_pad;
  logic [NSEL-1:0][WIDTH-1:0]  data_pad;

  // Zero-padded views so gnt indexes them without range issues.
  assign valid_pad = NSEL'(bus.req_valid);
  assign last_pad  = NSEL'(bus.req_last);
  assign data_pad  = (NSEL*WIDTH)'(bus.req_data);

  rr_pick #(.CNT(CNT), .CNT_WIDTH(CNT_WIDTH)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign out_free  = !bus.out_valid || bus.out_ready;
  assign beat      = (state == BUSY) && out_free && valid_pad[gnt];
  assign beat_last = beat && last_pad[gnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = BUSY;
      BUSY:    if (beat_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is combinational from the output stage so a stalled sink blocks
  // the grantee in the same cycle.
  always_comb begin
    bus.busy      = (state == BUSY);
    bus.req_ready = '0;
    if (state == BUSY && out_free) bus.req_ready = CNT'(1) << gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      gnt <= '0;
    end else begin
      if (state == IDLE && pick_found) gnt <= pick_idx;
      if (beat_last) ptr <= (gnt == CNT_WIDTH'(CNT - 1)) ? '0 : gnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_src   <= '0;
    end else if (beat) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= data_pad[gnt];
      bus.out_last  <= last_pad[gnt];
      bus.out_src   <= gnt;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
